// File: rtl/imem_fetch_unit.sv
// Writable instruction memory with a registered req/gnt/valid fetch port, a
// programming port and a post-reset NOP clear sequence. Optional macro: IMEM_FAULT_CHECK_EN.
module imem_fetch_unit #(
  parameter int                 DEPTH_LOG2 = 8,
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD   = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  input  logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic              fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   clr_cnt_q;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   fetch_idx, prog_idx;
  logic                    fetch_bad, prog_bad;

  assign fetch_idx = fetch_addr[DEPTH_LOG2+1:2];
  assign prog_idx  = prog_addr[DEPTH_LOG2+1:2];

`ifdef IMEM_FAULT_CHECK_EN
  // Misaligned, or any bit set above the word index, is outside the array.
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign prog_bad  = (prog_addr[1:0]  != 2'b00) || ((prog_addr  >> (DEPTH_LOG2 + 2)) != '0);
`else
  assign fetch_bad = 1'b0;
  assign prog_bad  = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[1:0], fetch_addr[ADDR_W-1:DEPTH_LOG2+2],
                              prog_addr[1:0],  prog_addr[ADDR_W-1:DEPTH_LOG2+2]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    fetch_gnt = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (&clr_cnt_q) state_d = RUN;
      end
      RUN: fetch_gnt = fetch_req && (!inst_valid || fetch_ready);
    endcase
  end

  // NOTE: the array has no reset; the clear sequence initialises it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_cnt_q] <= NOP_WORD;
    else if (prog_we && !prog_bad)
      mem[prog_idx] <= prog_data;
  end

  // NOTE: non-blocking assignments make the same-cycle read see the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      fault      <= 1'b0;
    end else if (fetch_gnt) begin
      inst_valid <= 1'b1;
      inst       <= fetch_bad ? NOP_WORD : mem[fetch_idx];
      fault      <= fetch_bad;
    end else if (!inst_valid || fetch_ready) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios plus a randomized
// phase checked against a word-array model. Honors IMEM_FAULT_CHECK_EN.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_gnt;
  logic        fetch_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic        fault;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  imem_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_ready(fetch_ready), .inst_valid(inst_valid),
    .inst(inst), .fault(fault), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the memory as a word array plus the visible output registers.
  logic [31:0] mmem [256];
  int          clear_left;
  bit          m_valid;
  logic [31:0] m_inst;
  bit          m_fault;

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef IMEM_FAULT_CHECK_EN
    return (a % 4 != 0) || (a >= 32'd1024);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_gnt();
    return (clear_left == 0) && fetch_req && (!m_valid || fetch_ready);
  endfunction

  task automatic model_edge();
    int fi, pi;
    fi = int'((fetch_addr / 4) % 256);
    pi = int'((prog_addr / 4) % 256);
    if (m_gnt()) begin
      m_valid = 1'b1;
      m_fault = addr_bad(fetch_addr);
      m_inst  = m_fault ? 32'h0 : mmem[fi];
    end else if (!m_valid || fetch_ready) begin
      m_valid = 1'b0;
    end
    if (clear_left > 0) begin
      mmem[256 - clear_left] = 32'h0;
      clear_left--;
    end else if (prog_we && !addr_bad(prog_addr)) begin
      mmem[pi] = prog_data;
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_ready = 1'b0; prog_we = 1'b0;
    fetch_addr = '0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_valid = 1'b0; m_inst = '0; m_fault = 1'b0; clear_left = 256;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    assert_reset();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || fault !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b inst=%h f=%b busy=%b exp v=0 inst=0 f=0 busy=1",
               inst_valid, inst, fault, busy);
    end
    release_reset();
  endtask

  task automatic test_clear();
    int bad_busy = 0, bad_gnt = 0;
    // Requests and writes aimed at index 0 during clear must be refused or dropped.
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h0;
    prog_we = 1'b1; prog_addr = 32'h0; prog_data = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) begin
      if (busy !== 1'b1) bad_busy++;
      if (fetch_gnt !== 1'b0) bad_gnt++;
      if (i == 255) begin fetch_req = 1'b0; prog_we = 1'b0; end
      clk_step();
    end
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_busy got %0d bad cycles, end busy=%b exp 0 bad, end busy=0", bad_busy, busy);
    end
    checks++;
    if (bad_gnt != 0) begin
      errors++;
      $display("FAIL clear_gnt got %0d granted cycles exp 0", bad_gnt);
    end
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    checks++;
    if (fetch_gnt !== 1'b1) begin
      errors++;
      $display("FAIL first_gnt got %b exp 1", fetch_gnt);
    end
    clk_step();
    fetch_addr = 32'h3FC;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0) begin
      errors++;
      $display("FAIL clear_word0 got v=%b inst=%h exp v=1 inst=00000000", inst_valid, inst);
    end
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0) begin
      errors++;
      $display("FAIL clear_word255 got v=%b inst=%h exp v=1 inst=00000000", inst_valid, inst);
    end
    clk_step();
  endtask

  task automatic test_prog_fetch();
    prog_we = 1'b1; prog_addr = 32'h004; prog_data = 32'h00221820;
    clk_step();
    prog_addr = 32'h008; prog_data = 32'hAC230000;
    clk_step();
    prog_we = 1'b0;
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h004;
    clk_step();
    fetch_addr = 32'h008;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h00221820) begin
      errors++;
      $display("FAIL pf_first got v=%b inst=%h exp v=1 inst=00221820", inst_valid, inst);
    end
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'hAC230000) begin
      errors++;
      $display("FAIL pf_second got v=%b inst=%h exp v=1 inst=ac230000", inst_valid, inst);
    end
    clk_step();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'hAC230000) begin
      errors++;
      $display("FAIL pf_drain got v=%b inst=%h exp v=0 inst=ac230000", inst_valid, inst);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h004;
    clk_step();
    fetch_ready = 1'b0; fetch_addr = 32'h008;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (fetch_gnt !== 1'b0) bad++;
      clk_step();
      if (inst_valid !== 1'b1 || inst !== 32'h00221820) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad samples (inst=%h v=%b) exp 0", bad, inst, inst_valid);
    end
    fetch_ready = 1'b1;
    #1;
    checks++;
    if (fetch_gnt !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_gnt got %b exp 1", fetch_gnt);
    end
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst !== 32'hAC230000 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_next got v=%b inst=%h exp v=1 inst=ac230000", inst_valid, inst);
    end
    clk_step();
  endtask

  task automatic test_collision();
    prog_we = 1'b1; prog_addr = 32'h010; prog_data = 32'h12345678;
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h010;
    clk_step();
    prog_we = 1'b0;
    checks++;
    if (inst !== 32'h0) begin
      errors++;
      $display("FAIL collide_old got %h exp 00000000", inst);
    end
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst !== 32'h12345678) begin
      errors++;
      $display("FAIL collide_new got %h exp 12345678", inst);
    end
    clk_step();
  endtask

  task automatic test_wrap();
    logic [31:0] e_inst;
    logic        e_fault;
`ifdef IMEM_FAULT_CHECK_EN
    e_inst = 32'h0; e_fault = 1'b1;
`else
    e_inst = 32'h00221820; e_fault = 1'b0;
`endif
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h404;
    clk_step();
    fetch_addr = 32'h006;
    checks++;
    if (inst !== e_inst || fault !== e_fault || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_404 got inst=%h f=%b v=%b exp inst=%h f=%b v=1",
               inst, fault, inst_valid, e_inst, e_fault);
    end
    clk_step();
    fetch_addr = 32'h004;
    checks++;
    if (inst !== e_inst || fault !== e_fault) begin
      errors++;
      $display("FAIL misalign_006 got inst=%h f=%b exp inst=%h f=%b", inst, fault, e_inst, e_fault);
    end
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst !== 32'h00221820 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got inst=%h f=%b exp inst=00221820 f=0", inst, fault);
    end
    clk_step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
    if ($urandom_range(0, 7) == 0) a = a | (32'h400 << $urandom_range(0, 5));
    return a;
  endfunction

  task automatic test_random();
    int bad = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_ready = ($urandom_range(0, 2) != 0);
      fetch_addr  = rand_addr();
      prog_we     = ($urandom_range(0, 3) == 0);
      prog_addr   = rand_addr();
      prog_data   = $urandom;
      #1;
      if (fetch_gnt !== m_gnt()) begin
        bad++;
        $display("FAIL rnd_gnt cyc %0d got %b exp %b", cyc, fetch_gnt, m_gnt());
      end
      clk_step();
      if (inst_valid !== m_valid || inst !== m_inst || fault !== m_fault || busy !== 1'b0) begin
        bad++;
        $display("FAIL rnd_out cyc %0d got v=%b inst=%h f=%b busy=%b exp v=%b inst=%h f=%b busy=0",
                 cyc, inst_valid, inst, fault, busy, m_valid, m_inst, m_fault);
      end
    end
    checks++;
    if (bad != 0) errors++;
    idle_inputs();
    clk_step();
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    // Reset during a stall must drop inst_valid at once.
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h004;
    clk_step();
    fetch_ready = 1'b0;
    clk_step();
    assert_reset();
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got v=%b inst=%h busy=%b exp v=0 inst=0 busy=1", inst_valid, inst, busy);
    end
    idle_inputs();
    release_reset();
    repeat (100) clk_step();
    assert_reset();
    checks++;
    if (inst_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_clear got v=%b busy=%b exp v=0 busy=1", inst_valid, busy);
    end
    release_reset();
    while (busy === 1'b1 && cnt < 1000) begin
      clk_step();
      cnt++;
    end
    checks++;
    if (cnt != 256) begin
      errors++;
      $display("FAIL reclear_len got %0d busy cycles exp 256", cnt);
    end
    fetch_req = 1'b1; fetch_ready = 1'b1; fetch_addr = 32'h004;
    clk_step();
    fetch_req = 1'b0;
    checks++;
    if (inst !== 32'h0 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL reclear_word got v=%b inst=%h exp v=1 inst=00000000", inst_valid, inst);
    end
    clk_step();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_prog_fetch();
    test_stall();
    test_collision();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, synchronous, writable instruction memory for the single-cycle/multicycle MIPS core. It replaces the fixed 256-word combinational instruction ROM with a registered fetch port that uses a request/grant/valid handshake and supports core stalls. It adds a runtime programming port for loading test programs from the bench or a boot loader. After every reset, a hardware clear sequence fills the array with NOPs.

## Interface
- DEPTH_LOG2, 8, log2 of word count (DEPTH = 2**DEPTH_LOG2)
- ADDR_W, 32, byte-address width of fetch and program ports
- DATA_W, 32, instruction width
- NOP_WORD, 32'h00000000, value written during clear and returned on fault
- clk  input  1  system clock, all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- fetch_req  input  1  core requests instruction at fetch_addr
- fetch_addr  input  ADDR_W  byte address; word index = fetch_addr[DEPTH_LOG2+1:2]
- fetch_gnt  output  1  combinational: request accepted this cycle
- fetch_ready  input  1  core consumes current inst this cycle
- inst_valid  output  1  inst holds a fetched word
- inst  output  DATA_W  fetched instruction (registered)
- fault  output  1  fetch fault flag, aligned with inst_valid (constant 0 when macro absent)
- prog_we  input  1  write strobe
- prog_addr  input  ADDR_W  byte address, same index rule as fetch
- prog_data  input  DATA_W  word to write
- busy  output  1  clear sequence in progress

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with clear counter = 0.
- CLEAR: each cycle writes NOP_WORD to mem[counter] and increments the counter. At counter = DEPTH-1, that write completes and the state moves to RUN. Duration is exactly DEPTH cycles.
- In CLEAR: busy = 1, fetch_gnt = 0 and prog_we is ignored (write dropped).
- RUN: busy = 0. It stays in RUN until reset.
- fetch_gnt = (state == RUN) && fetch_req && (!inst_valid || fetch_ready).
- On gnt: inst <= mem[index] and inst_valid <= 1.
- Stall: inst_valid && !fetch_ready holds inst, inst_valid and fault unchanged. No new request is accepted.
- Drain: (!inst_valid || fetch_ready) && !fetch_req sets inst_valid <= 0. inst keeps its last value.
- Program write in RUN: mem[prog index] <= prog_data. prog_addr[1:0] and upper bits are ignored.
- Read-before-write: a same-cycle fetch gnt and prog_we to the same index returns the old word. The new word is visible to fetches granted from the next cycle on.
- Without the macro, address bits above DEPTH_LOG2+1 are ignored (index wraps modulo DEPTH) and fetch_addr[1:0] is ignored.

## Timing
- Fetch latency: 1 cycle from gnt edge to inst_valid/inst.
- Back-to-back: with fetch_ready = 1 and fetch_req = 1, one instruction per cycle.
- Program write latency: 1 cycle.
- Reset values: inst_valid = 0, inst = 0, fault = 0, busy = 1, state = CLEAR, counter = 0.
- Asserting rst_n low mid-CLEAR or mid-stall aborts immediately. The clear restarts from index 0 after release.
- Memory contents are not reset asynchronously; the clear sequence overwrites them.
- First possible gnt is DEPTH cycles after rst_n deasserts.

## Configuration
- IMEM_FAULT_CHECK_EN defined: a granted fetch is faulting when fetch_addr[1:0] != 0 or any fetch_addr bit above DEPTH_LOG2+1 is 1.
  - On a faulting fetch: fault <= 1, inst <= NOP_WORD, inst_valid <= 1 (handshake unchanged).
  - On a non-faulting gnt: fault <= 0.
  - prog_we to an out-of-range or misaligned address is dropped.
- IMEM_FAULT_CHECK_EN undefined: fault is tied to 0, addresses wrap or truncate, and all writes in RUN are accepted.

## Test plan
- Clear: release rst_n. Required: busy = 1 for exactly 256 cycles (default), fetch_gnt = 0 throughout, then a fetch of 0x0 and of 0x3FC both return 32'h00000000.
- Program/fetch: write 0x00221820 to 0x004 and 0xAC230000 to 0x008. Fetch 0x004 then 0x008 with fetch_ready = 1. Required: inst = 0x00221820 then 0xAC230000 on consecutive cycles, 1-cycle latency.
- Stall: fetch 0x004, hold fetch_ready = 0 for 3 cycles with fetch_req = 1. Required: inst = 0x00221820 held, fetch_gnt = 0 for those cycles. Next gnt occurs in the cycle fetch_ready = 1.
- Collision: same cycle, prog_we to 0x010 with 0x12345678 and fetch 0x010 (old value 0). Required: inst = 0. Refetch next cycle gives 0x12345678.
- Wrap/fault: fetch 0x404 after programming 0x004.
  - Macro off: inst = 0x00221820, fault = 0.
  - Macro on: inst = NOP_WORD, fault = 1.
  - Macro on, fetch 0x006: fault = 1.
- Reset mid-operation: assert rst_n low at clear counter 100, release. Required: inst_valid = 0 immediately, busy = 1 for a full 256 cycles again.
